// File: rtl/apb_fifo_arbiter_if.sv
// apb_fifo_arbiter_if: APB pins between the arbiter (master) and the FIFO slave.
interface apb_fifo_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              PSEL, PENABLE, PWRITE, PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY, PSLVERR;
   logic [DATA_W-1:0] PRDATA;
   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PREADY, PSLVERR, PRDATA
   );
   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PREADY, PSLVERR, PRDATA
   );
endinterface

// File: rtl/apb_fifo_arbiter.sv
// apb_fifo_arbiter: round-robin two-client APB master for a single-address-bit FIFO slave.
module apb_fifo_arbiter #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   apb_fifo_arbiter_if.master apb
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2;
   logic [1:0]        r_state;
   logic              r_ptr, r_gnt;
   logic [7:0]        r_cnt;
   logic              w_gnt, w_wr, w_done, w_err;
   logic [DATA_W-1:0] w_wdata;
   logic [7:0]        w_cnt_nxt;
   always_comb begin
      w_gnt     = (req0 & req1) ? r_ptr : req1;
      w_wr      = w_gnt ? wr1 : wr0;
      w_wdata   = w_gnt ? wdata1 : wdata0;
      w_cnt_nxt = r_cnt + 8'd1;
      w_done    = apb.PREADY | (w_cnt_nxt == 8'(TIMEOUT));
      w_err     = ~apb.PREADY | apb.PSLVERR;
   end
   // PWRITE/PWDATA double as the latched request; they stay stable through ACCESS
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         r_state     <= S_IDLE;
         r_ptr       <= 1'b0;
         r_gnt       <= 1'b0;
         r_cnt       <= 8'd0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err0        <= 1'b0;
         err1        <= 1'b0;
         rdata       <= '0;
         busy        <= 1'b0;
         apb.PSEL    <= 1'b0;
         apb.PENABLE <= 1'b0;
         apb.PWRITE  <= 1'b0;
         apb.PADDR   <= 1'b0;
         apb.PWDATA  <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (r_state)
            S_IDLE: if (req0 | req1) begin
               r_state    <= S_SETUP;
               r_gnt      <= w_gnt;
               r_ptr      <= ~w_gnt;
               r_cnt      <= 8'd0;
               busy       <= 1'b1;
               apb.PSEL   <= 1'b1;
               apb.PWRITE <= w_wr;
               apb.PADDR  <= ~w_wr;
               apb.PWDATA <= w_wr ? w_wdata : '0;
            end
            S_SETUP: begin
               r_state     <= S_ACCESS;
               apb.PENABLE <= 1'b1;
            end
            S_ACCESS: if (w_done) begin
               r_state     <= S_IDLE;
               busy        <= 1'b0;
               apb.PSEL    <= 1'b0;
               apb.PENABLE <= 1'b0;
               ack0        <= ~r_gnt;
               ack1        <= r_gnt;
               err0        <= ~r_gnt & w_err;
               err1        <= r_gnt & w_err;
               if (apb.PREADY & ~apb.PSLVERR & ~apb.PWRITE) rdata <= apb.PRDATA;
            end else
               r_cnt <= w_cnt_nxt;
            default: r_state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_apb_fifo_arbiter.sv
// tb_apb_fifo_arbiter: vector table, randomized run against a transaction-level model,
// and hand-written reset / round-robin sequences.
module tb_apb_fifo_arbiter;
   localparam int TO    = 4;
   localparam int DEPTH = 4;

   typedef struct {
      bit         c;
      bit         wr;
      logic [7:0] wd;
      int         waits;
      bit         err;
      logic [7:0] rd;
      int         lat;
   } vec_t;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
   logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
   logic       ack0, ack1, err0, err1, busy;
   logic [7:0] rdata;
   int         checks = 0, failures = 0;
   int         sl_waits = 0, sl_cnt = 0;
   logic [7:0] sl_q[$];
   logic [7:0] ref_q[$];
   logic [7:0] ref_rd = 8'h00;
   bit         ref_ptr = 1'b0;

   apb_fifo_arbiter_if #(.DATA_W(8)) bus();

   apb_fifo_arbiter #(.DATA_W(8), .TIMEOUT(TO)) dut (
      .PCLK(clk), .PRESETn(rst_n),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata(rdata), .busy(busy), .apb(bus)
   );

   always #5 clk = ~clk;

   // FIFO slave: answers an ACCESS cycle after sl_waits wait states, errors on full/empty
   always @(negedge clk) begin
      if (bus.PSEL && bus.PENABLE && sl_cnt >= sl_waits) begin
         bus.PREADY = 1'b1;
         if (bus.PWRITE) begin
            bus.PSLVERR = sl_q.size() >= DEPTH;
            bus.PRDATA  = 8'hEE;
            if (!bus.PSLVERR) sl_q.push_back(bus.PWDATA);
         end else begin
            bus.PSLVERR = sl_q.size() == 0;
            if (bus.PSLVERR) bus.PRDATA = 8'hEE;
            else bus.PRDATA = sl_q.pop_front();
         end
      end else begin
         bus.PREADY  = 1'b0;
         bus.PSLVERR = 1'b0;
         bus.PRDATA  = 8'h5A;
         sl_cnt = (bus.PSEL && bus.PENABLE) ? sl_cnt + 1 : 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction-level reference: FIFO contents, last pop data, round-robin preference
   task automatic model(input bit c, input bit wr, input logic [7:0] wd, input int waits,
                        output bit e_err, output logic [7:0] e_rd, output int e_lat);
      ref_ptr = !c;
      if (waits >= TO) begin
         e_err = 1'b1;
         e_lat = 2 + TO;
      end else begin
         e_lat = 3 + waits;
         if (wr) begin
            e_err = ref_q.size() >= DEPTH;
            if (!e_err) ref_q.push_back(wd);
         end else begin
            e_err = ref_q.size() == 0;
            if (!e_err) ref_rd = ref_q.pop_front();
         end
      end
      e_rd = ref_rd;
   endtask

   task automatic xfer(input bit c, input bit wr, input logic [7:0] wd, input int waits,
                       input bit e_err, input logic [7:0] e_rd, input int e_lat, input string nm);
      int n = 0, bsy = 0;
      logic [1:0] ak = 2'b00;
      sl_waits = waits;
      if (c) begin req1 = 1'b1; wr1 = wr; wdata1 = wd; end
      else begin req0 = 1'b1; wr0 = wr; wdata0 = wd; end
      while (ak == 2'b00 && n < 40) begin
         @(negedge clk);
         n++;
         ak = {ack1, ack0};
         if (busy) bsy++;
         if (n == 1)
            chk({nm, "_setup"}, 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}),
                32'({1'b1, 1'b0, wr, ~wr, wr ? wd : 8'h00}));
         if (n == 2)
            chk({nm, "_access"}, 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}),
                32'({1'b1, 1'b1, wr, ~wr, wr ? wd : 8'h00}));
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk({nm, "_ack"}, 32'(ak), c ? 2 : 1);
      chk({nm, "_err"}, 32'({err1, err0}), e_err ? (c ? 2 : 1) : 0);
      chk({nm, "_rdata"}, 32'(rdata), 32'(e_rd));
      chk({nm, "_lat"}, n, e_lat);
      chk({nm, "_busy"}, bsy, e_lat - 1);
      chk({nm, "_idle"}, 32'({bus.PSEL, bus.PENABLE, busy}), 0);
      @(negedge clk);
      chk({nm, "_pulse"}, 32'({ack1, ack0, err1, err0}), 0);
   endtask

   task automatic both(input bit wa, input bit wb, input logic [7:0] da, input logic [7:0] db,
                       input int w);
      bit         e[2];
      logic [7:0] r[2];
      bit         ord[2];
      int         l;
      int         k = 0, n = 0;
      ord[0] = ref_ptr;
      ord[1] = !ref_ptr;
      for (int j = 0; j < 2; j++)
         model(ord[j], ord[j] ? wb : wa, ord[j] ? db : da, w, e[j], r[j], l);
      sl_waits = w;
      req0 = 1'b1; wr0 = wa; wdata0 = da;
      req1 = 1'b1; wr1 = wb; wdata1 = db;
      while (k < 2 && n < 60) begin
         @(negedge clk);
         n++;
         if (ack0 | ack1) begin
            chk("both_order", 32'({ack1, ack0}), ord[k] ? 2 : 1);
            chk("both_err", 32'(ack1 ? err1 : err0), 32'(e[k]));
            chk("both_rdata", 32'(rdata), 32'(r[k]));
            if (ack0) req0 = 1'b0;
            else req1 = 1'b0;
            k++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk("both_done", k, 2);
      @(negedge clk);
   endtask

   initial begin
      vec_t       tbl[12];
      bit         c, wa, wb, e;
      logic [7:0] da, db, r;
      int         w, l, k;
      int         t[6];
      bit         who[6];
      tbl = '{
         '{1'b0, 1'b1, 8'hA5, 0, 1'b0, 8'h00, 3},
         '{1'b1, 1'b0, 8'h00, 0, 1'b0, 8'hA5, 3},
         '{1'b0, 1'b1, 8'h11, 0, 1'b0, 8'hA5, 3},
         '{1'b0, 1'b1, 8'h22, 1, 1'b0, 8'hA5, 4},
         '{1'b0, 1'b1, 8'h33, 0, 1'b0, 8'hA5, 3},
         '{1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h11, 3},
         '{1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h22, 3},
         '{1'b1, 1'b0, 8'h00, 2, 1'b0, 8'h33, 5},
         '{1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h33, 3},
         '{1'b0, 1'b1, 8'h44, 0, 1'b0, 8'h33, 3},
         '{1'b1, 1'b1, 8'h55, 9, 1'b1, 8'h33, 6},
         '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h44, 3}
      };
      repeat (2) @(negedge clk);
      chk("reset_ctrl", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, busy, ack0, ack1, err0, err1}), 0);
      chk("reset_data", 32'({rdata, bus.PWDATA}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 12; i++)
         xfer(tbl[i].c, tbl[i].wr, tbl[i].wd, tbl[i].waits, tbl[i].err, tbl[i].rd, tbl[i].lat,
              $sformatf("vec%0d", i));
      ref_ptr = !tbl[11].c;
      ref_rd  = tbl[11].rd;
      for (int i = 0; i < 60; i++) begin
         wa = 1'($urandom_range(0, 1));
         wb = 1'($urandom_range(0, 1));
         da = 8'($urandom);
         db = 8'($urandom);
         w  = ($urandom_range(0, 7) == 0) ? TO + 2 : int'($urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0) both(wa, wb, da, db, w);
         else begin
            c = 1'($urandom_range(0, 1));
            model(c, wa, da, w, e, r, l);
            xfer(c, wa, da, w, e, r, l, "rnd");
         end
      end
      // reset in the middle of an ACCESS wait from client 0
      sl_waits = 255;
      req0 = 1'b1; wr0 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({bus.PSEL, bus.PENABLE, busy, ack0, ack1, err0, err1}), 0);
      chk("rst_rdata", 32'(rdata), 0);
      req0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      repeat (8) begin
         @(negedge clk);
         if (ack0 | ack1 | busy) k++;
      end
      chk("rst_no_ack", k, 0);
      // both clients held high: strict alternation starting at client 0
      sl_waits = 0;
      req0 = 1'b1; wr0 = 1'b1; wdata0 = 8'h77;
      req1 = 1'b1; wr1 = 1'b0;
      k = 0;
      for (int n = 1; n <= 40 && k < 6; n++) begin
         @(negedge clk);
         if (ack0 | ack1) begin
            t[k]   = n;
            who[k] = ack1;
            k++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk("rr_count", k, 6);
      if (k > 0) chk("rr_first_lat", t[0], 3);
      for (int j = 0; j < k; j++) chk("rr_order", 32'(who[j]), j % 2);
      for (int j = 2; j < k; j++) chk("rr_period", t[j] - t[j-2], 6);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
